// File: rtl/dac_sink_pkg.sv
// Shared types and sample conversion for the serial DAC sink.
package dac_sink_pkg;

    typedef enum logic [1:0] {IDLE, PRIME, RUN} ctl_state_t;
    typedef enum logic [1:0] {F_IDLE, F_LOW, F_HIGH, F_TAIL} frm_state_t;

    // Round-half-up to db bits, clamp positive overflow, optionally flip MSB to offset binary.
    function automatic logic [63:0] q31_to_dac(input logic [63:0] x, input int dw,
                                               input int db, input bit ob);
        logic [63:0] mask;
        logic [63:0] sum;
        logic [63:0] w;
        mask = (64'd1 << dw) - 64'd1;
        sum  = (x + (64'd1 << (dw - db - 1))) & mask;
        if (!x[dw-1] && sum[dw-1])
            w = (64'd1 << (db - 1)) - 64'd1;
        else
            w = sum >> (dw - db);
        w = w & ((64'd1 << db) - 64'd1);
        if (ob)
            w = w ^ (64'd1 << (db - 1));
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage, combinational head read and occupancy count.
module sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  wr_dat_i,
    input  logic          pop_i,
    output logic [W-1:0]  rd_dat_o,
    output logic [LW-1:0] level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [LW-1:0] level_q, level_d;

    always_comb begin
        level_d = level_q;
        case ({push_i, pop_i})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_i)
            mem_q[wr_q] <= wr_dat_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (push_i)
                wr_q <= wr_q + AW'(1);
            if (pop_i)
                rd_q <= rd_q + AW'(1);
            level_q <= level_d;
        end
    end

    assign rd_dat_o = mem_q[rd_q];
    assign level_o  = level_q;

endmodule

// File: rtl/dac_spi_sink.sv
// AXI-Stream Q1.31 sink feeding a serial DAC: converts on write, buffers, and sends one
// SPI frame per sample tick; its fixed output rate is the upstream back-pressure.
module dac_spi_sink
    import dac_sink_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int DAC_BITS      = 16,
    parameter int FIFO_DEPTH    = 8,
    parameter int CLK_DIV       = 2,
    parameter int SAMPLE_PERIOD = 80,
    parameter int OFFSET_BINARY = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          enable,
    output logic                          dac_sclk,
    output logic                          dac_mosi,
    output logic                          dac_cs_n,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   underrun_cnt
);
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;
    localparam int CW  = $clog2(SAMPLE_PERIOD);
    localparam int DVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW  = $clog2(DAC_BITS);
    localparam logic [DAC_BITS-1:0] IDLE_WORD = {(OFFSET_BINARY != 0), {(DAC_BITS-1){1'b0}}};

    ctl_state_t          ctl_q;
    frm_state_t          f_q;
    logic [CW-1:0]       cnt_q;
    logic                stop_q, rdy_q;
    logic [15:0]         und_q;
    logic [DAC_BITS-1:0] last_q, sh_q;
    logic [DVW-1:0]      div_q;
    logic [BW-1:0]       bit_q;
    logic                sclk_q, mosi_q, cs_q;

    logic [DAC_BITS-1:0] wr_dat, rd_dat, load_word;
    logic [LW-1:0]       lvl;
    logic                push, pop, tick, div_end;

    assign wr_dat = DAC_BITS'(q31_to_dac(64'(s_axis_tdata), DATA_WIDTH, DAC_BITS,
                                         OFFSET_BINARY != 0));
    assign s_axis_tready = rdy_q && (lvl != LW'(FIFO_DEPTH));
    assign push      = s_axis_tvalid && s_axis_tready;
    assign tick      = (ctl_q == RUN) && enable && !stop_q && (cnt_q == '0);
    assign pop       = tick && (lvl != '0);
    assign load_word = (lvl != '0) ? rd_dat : last_q;
    assign div_end   = (div_q == DVW'(CLK_DIV - 1));

    sync_fifo #(.W(DAC_BITS), .DEPTH(FIFO_DEPTH), .LW(LW)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (push),
        .wr_dat_i (wr_dat),
        .pop_i    (pop),
        .rd_dat_o (rd_dat),
        .level_o  (lvl)
    );

    // Once a stop is requested the tick counter keeps running but ticks are masked until IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q  <= IDLE;
            cnt_q  <= '0;
            stop_q <= 1'b0;
            rdy_q  <= 1'b0;
            und_q  <= '0;
            last_q <= IDLE_WORD;
        end else begin
            rdy_q <= 1'b1;
            case (ctl_q)
                IDLE: if (enable) ctl_q <= PRIME;
                PRIME: begin
                    if (!enable) begin
                        ctl_q <= IDLE;
                    end else if (lvl >= LW'(FIFO_DEPTH / 2)) begin
                        ctl_q  <= RUN;
                        cnt_q  <= '0;
                        stop_q <= 1'b0;
                    end
                end
                RUN: begin
                    cnt_q <= (cnt_q == CW'(SAMPLE_PERIOD - 1)) ? '0 : cnt_q + CW'(1);
                    if (!enable || stop_q) begin
                        stop_q <= 1'b1;
                        if (f_q == F_IDLE) begin
                            ctl_q  <= IDLE;
                            stop_q <= 1'b0;
                        end
                    end
                end
                default: ctl_q <= IDLE;
            endcase
            if (tick) begin
                last_q <= load_word;
                if (lvl == '0 && und_q != 16'hFFFF)
                    und_q <= und_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q    <= F_IDLE;
            div_q  <= '0;
            bit_q  <= '0;
            sh_q   <= '0;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
            cs_q   <= 1'b1;
        end else if (tick) begin
            f_q    <= F_LOW;
            div_q  <= '0;
            bit_q  <= BW'(DAC_BITS - 1);
            sh_q   <= load_word;
            mosi_q <= load_word[DAC_BITS-1];
            cs_q   <= 1'b0;
            sclk_q <= 1'b0;
        end else begin
            case (f_q)
                F_LOW: begin
                    div_q <= div_end ? '0 : div_q + DVW'(1);
                    if (div_end) begin
                        sclk_q <= 1'b1;
                        f_q    <= F_HIGH;
                    end
                end
                F_HIGH: begin
                    div_q <= div_end ? '0 : div_q + DVW'(1);
                    if (div_end) begin
                        sclk_q <= 1'b0;
                        if (bit_q == '0) begin
                            f_q <= F_TAIL;
                        end else begin
                            bit_q  <= bit_q - BW'(1);
                            sh_q   <= sh_q << 1;
                            mosi_q <= sh_q[DAC_BITS-2];
                            f_q    <= F_LOW;
                        end
                    end
                end
                F_TAIL: begin
                    div_q <= div_end ? '0 : div_q + DVW'(1);
                    if (div_end) begin
                        cs_q   <= 1'b1;
                        mosi_q <= 1'b0;
                        f_q    <= F_IDLE;
                    end
                end
                default: f_q <= F_IDLE;
            endcase
        end
    end

    assign dac_sclk     = sclk_q;
    assign dac_mosi     = mosi_q;
    assign dac_cs_n     = cs_q;
    assign fifo_level   = lvl;
    assign underrun_cnt = und_q;

endmodule

// File: tb/tb_dac_spi_sink.sv
// Randomized bench for dac_spi_sink: an SPI-pin monitor rebuilds frames and compares them
// against a queue-based model of the sample stream.
module tb_dac_spi_sink;
    localparam int DB    = 16;
    localparam int SP    = 80;
    localparam int CD    = 2;
    localparam int OB    = 1;
    localparam int FRAME = 2 * CD * DB + CD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic        enable = 1'b0;
    logic        sclk, mosi, cs_n;
    logic [3:0]  level;
    logic [15:0] und;

    dac_spi_sink dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .enable        (enable),
        .dac_sclk      (sclk),
        .dac_mosi      (mosi),
        .dac_cs_n      (cs_n),
        .fifo_level    (level),
        .underrun_cnt  (und)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Rounded, clamped value in DAC steps, then shifted into offset binary.
    function automatic int conv(input logic [31:0] x);
        longint v, r;
        v = longint'($signed(x));
        r = (v + 32768) >>> 16;
        if (r > 32767) r = 32767;
        if (OB != 0) r = r + 32768;
        return int'(r & 65535);
    endfunction

    int     q[$];
    int     got_words[$];
    int     last_w, und_exp, exp_word, bits, word, low_cyc, viol = 0;
    int     n_frames = 0, n_starts = 0;
    logic   pend_v, prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0, in_frame = 1'b0;
    logic [31:0] pend_d;
    longint last_fall = -1, fall_cyc = -1;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            last_w    = (OB != 0) ? 32768 : 0;
            und_exp   = 0;
            pend_v    = 1'b0;
            prev_cs   = 1'b1;
            prev_sclk = 1'b0;
            prev_mosi = 1'b0;
            in_frame  = 1'b0;
            last_fall = -1;
        end else begin
            if (prev_cs && !cs_n) begin
                if (last_fall >= 0 && cyc - last_fall < 250)
                    chk("tick_spacing", cyc - last_fall, SP);
                last_fall = cyc;
                fall_cyc  = cyc;
                if (q.size() > 0) exp_word = q.pop_front();
                else begin
                    exp_word = last_w;
                    if (und_exp < 65535) und_exp++;
                end
                last_w = exp_word;
                in_frame = 1'b1;
                bits = 0; word = 0; low_cyc = 0;
                n_starts++;
            end
            if (pend_v) q.push_back(conv(pend_d));
            if (!cs_n) low_cyc++;
            if (!prev_sclk && sclk) begin
                word = (word << 1) | int'(mosi);
                bits++;
            end
            if (mosi != prev_mosi && !(prev_sclk && !sclk) && prev_cs == cs_n) viol++;
            if (cs_n && sclk) viol++;
            if (!prev_cs && cs_n && in_frame) begin
                chk("frame_len", low_cyc, FRAME);
                chk("frame_bits", bits, DB);
                chk("frame_word", word, exp_word);
                chk("underrun_cnt", und, und_exp);
                chk("fifo_level", level, q.size());
                got_words.push_back(word);
                n_frames++;
                in_frame = 1'b0;
            end
            pend_v    = tvalid && tready;
            pend_d    = tdata;
            prev_cs   = cs_n;
            prev_sclk = sclk;
            prev_mosi = mosi;
        end
    end

    task automatic push(input logic [31:0] d);
        bit ok = 0;
        tvalid = 1'b1;
        tdata  = d;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (tready) ok = 1;
            @(posedge clk);
            #1;
        end
        tvalid = 1'b0;
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_starts(input int target, input int budget);
        int i = 0;
        while (n_starts < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (n_starts < target) chk("wait_frame_start_timeout", n_starts, target);
    endtask

    task automatic wait_sclk_rises(input int n);
        int seen = 0;
        logic p = sclk;
        for (int i = 0; i < 400 && seen < n; i++) begin
            @(negedge clk);
            if (!p && sclk) seen++;
            p = sclk;
        end
        if (seen < n) chk("sclk_timeout", seen, n);
    endtask

    int          lvl0, s0, f0, acc_n;
    bit          acc;
    longint      c0;
    logic [31:0] d;
    int          dir_words[6] = '{32'hC000, 32'hFFFF, 32'h0000, 32'h8001, 32'h8001, 32'h8001};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", tready, 0);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_level", level, 0);
        chk("rst_underrun", und, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("tready_after_rst", tready, 1);

        // Three samples are below the priming threshold.
        push(32'h4000_0000);
        push(32'h7FFF_FFFF);
        push(32'h8000_0000);
        enable = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("prime_no_frame", last_fall, -1);
        chk("prime_level", level, 3);
        push(32'h0000_8000);
        c0 = cyc;
        chk("level_at_4", level, 4);
        wait_starts(1, 20);
        chk("prime_to_cs_low", fall_cyc - c0, 2);

        // Input stops after four samples: later frames repeat the last word.
        while (n_frames < 6 && cyc < c0 + 800) @(negedge clk);
        chk("underrun_after_6", und, 2);
        for (int i = 0; i < 6; i++)
            if (i < got_words.size()) chk("directed_word", got_words[i], dir_words[i]);
            else chk("directed_word_missing", i, got_words.size());

        // Random samples at roughly the drain rate, biased towards the saturation edge.
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(40, 100)) @(posedge clk);
            #1;
            d = $urandom;
            if ($urandom_range(0, 3) == 0) d = {1'b0, 15'h7FFF, 16'($urandom)};
            push(d);
        end

        // Continuous valid: FIFO fills, then one accept per sample period.
        tvalid = 1'b1;
        tdata  = $urandom;
        acc    = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            acc = tready;
            if (level == 4'd8) break;
            @(posedge clk);
            #1;
            if (acc) tdata = $urandom;
        end
        chk("bp_full_level", level, 8);
        chk("bp_tready_low", tready, 0);
        acc   = 0;
        acc_n = 0;
        repeat (10 * SP) begin
            @(posedge clk);
            #1;
            if (acc) tdata = $urandom;
            @(negedge clk);
            acc = tready;
            acc_n += int'(acc);
        end
        chk("bp_accepts_per_10_periods", acc_n, 10);
        @(posedge clk);
        #1;
        tvalid = 1'b0;

        // Drop enable at bit 5: frame completes, no further ticks, FIFO kept.
        wait_starts(n_starts + 1, 200);
        wait_sclk_rises(5);
        enable = 1'b0;
        lvl0 = int'(level);
        s0   = n_starts;
        f0   = n_frames;
        for (int i = 0; i < 100 && !cs_n; i++) @(negedge clk);
        repeat (300) @(negedge clk);
        chk("dis_cs_high", cs_n, 1);
        chk("dis_frame_done", n_frames, f0 + 1);
        chk("dis_no_tick", n_starts, s0);
        chk("dis_level_kept", level, lvl0);

        // Reset in the middle of bit 8.
        enable = 1'b1;
        wait_starts(s0 + 1, 200);
        wait_sclk_rises(8);
        chk("pre_rst_level_nonzero", level != 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_cs_n", cs_n, 1);
        chk("midrst_sclk", sclk, 0);
        chk("midrst_mosi", mosi, 0);
        chk("midrst_level", level, 0);
        chk("midrst_underrun", und, 0);
        chk("midrst_tready", tready, 0);
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_tready", tready, 1);
        chk("post_rst_cs_n", cs_n, 1);
        chk("mosi_stability_violations", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
